// File: rtl/battleship_shot_ctrl.sv
// battleship_shot_ctrl
// Sequential shot controller for the battleship scoring datapath.
// A shot (X, Y, Big) is accepted over a valid/ready handshake and its
// coordinates are checked. The one or nine target cells are then walked
// through the fixed ship layout, one cell per cycle. Only cells that have not
// been hit before are counted. Per-game state is kept here: the hit map,
// total hits, shots left, big bombs left, and game over / win.
//
// Ports
//   clock, reset        rising-edge clock, synchronous active-high reset
//   NewGame             start or restart a game (highest priority after reset)
//   ShotValid, X, Y     shot request and its coordinates (legal range 1..10)
//   Big                 request a 3x3 big-bomb shot
//   ShotReady           a shot can be accepted this cycle
//   ResultValid         one-cycle pulse; NumHits and BigUsed are valid
//   NumHits, BigUsed    new ship cells hit by the shot; shot ran as big
//   Invalid             one-cycle pulse; accepted request was out of range
//   TotalHits           distinct ship cells hit this game
//   ShotsLeft, BigLeft  remaining shots and big bombs
//   GameOver, Won       game finished; all 19 ship cells hit

module battleship_shot_ctrl #(
   parameter int MAX_SHOTS = 20,
   parameter int MAX_BIG   = 2,
   localparam int SW = $clog2(MAX_SHOTS + 1),
   localparam int BW = $clog2(MAX_BIG + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          NewGame,
   input  logic          ShotValid,
   input  logic [3:0]    X,
   input  logic [3:0]    Y,
   input  logic          Big,
   output logic          ShotReady,
   output logic          ResultValid,
   output logic [3:0]    NumHits,
   output logic          BigUsed,
   output logic          Invalid,
   output logic [4:0]    TotalHits,
   output logic [SW-1:0] ShotsLeft,
   output logic [BW-1:0] BigLeft,
   output logic          GameOver,
   output logic          Won
);

   typedef enum logic [2:0] {IDLE, READY, SCAN, REPORT, DONE} state_t;

   state_t        state, next_state;
   logic [18:0]   hit_map;
   logic [3:0]    lat_x, lat_y;
   logic          eff_big;
   logic [3:0]    cell_idx;
   logic [3:0]    acc;
   logic          invalid_q;

   logic          coord_ok;
   logic [1:0]    row, col;
   logic [4:0]    cx, cy;
   logic          on_board;
   logic [5:0]    lookup;
   logic          cell_new;
   logic [3:0]    last_idx;
   logic [4:0]    new_total;
   logic [SW-1:0] new_shots;

   // Maps an on-board cell to {is_ship, ship-cell index 0..18}; the index
   // selects this cell's bit in the hit map.
   function automatic logic [5:0] ship_lookup(input logic [3:0] x, input logic [3:0] y);
      logic [4:0] xe, ye;
      xe = {1'b0, x};
      ye = {1'b0, y};
      ship_lookup = 6'd0;
      if (x == 4'd2 && y >= 4'd8 && y <= 4'd10)
         ship_lookup = {1'b1, ye - 5'd8};
      else if (y == 4'd6 && x >= 4'd7 && x <= 4'd8)
         ship_lookup = {1'b1, xe - 5'd4};
      else if (y == 4'd3 && x >= 4'd2 && x <= 4'd6)
         ship_lookup = {1'b1, xe + 5'd3};
      else if (y == 4'd2 && x >= 4'd1 && x <= 4'd4)
         ship_lookup = {1'b1, xe + 5'd9};
      else if (y == 4'd1 && x >= 4'd2 && x <= 4'd4)
         ship_lookup = {1'b1, xe + 5'd12};
      else if (y == 4'd1 && x >= 4'd9 && x <= 4'd10)
         ship_lookup = {1'b1, xe + 5'd8};
   endfunction

   // Current target cell. A big shot walks the 3x3 block row-major from the
   // top-left corner. The latched center is at least 1, so the sums reach
   // 0 or 11 at the edges and never wrap. Those values are off board.
   always_comb begin
      row = 2'd1;
      col = 2'd1;
      if (eff_big) begin
         case (cell_idx)
            4'd0: begin row = 2'd0; col = 2'd0; end
            4'd1: begin row = 2'd0; col = 2'd1; end
            4'd2: begin row = 2'd0; col = 2'd2; end
            4'd3: begin row = 2'd1; col = 2'd0; end
            4'd4: begin row = 2'd1; col = 2'd1; end
            4'd5: begin row = 2'd1; col = 2'd2; end
            4'd6: begin row = 2'd2; col = 2'd0; end
            4'd7: begin row = 2'd2; col = 2'd1; end
            default: begin row = 2'd2; col = 2'd2; end
         endcase
      end
      cx       = {1'b0, lat_x} + {3'b000, col} - 5'd1;
      cy       = {1'b0, lat_y} + {3'b000, row} - 5'd1;
      on_board = (cx >= 5'd1) && (cx <= 5'd10) && (cy >= 5'd1) && (cy <= 5'd10);
      lookup   = ship_lookup(cx[3:0], cy[3:0]);
      cell_new = on_board && lookup[5] && !hit_map[lookup[4:0]];
      last_idx = eff_big ? 4'd8 : 4'd0;
      coord_ok = (X >= 4'd1) && (X <= 4'd10) && (Y >= 4'd1) && (Y <= 4'd10);
      // The shot counter cannot be zero while a shot is in flight, because
      // REPORT leaves for DONE when it reaches zero. The guard keeps it from
      // wrapping anyway.
      new_total = TotalHits + {1'b0, acc};
      new_shots = (ShotsLeft != '0) ? ShotsLeft - SW'(1) : ShotsLeft;
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next state and outputs. NewGame overrides whatever the FSM would do,
   // which also aborts an in-flight shot before it can report.
   always_comb begin
      next_state  = state;
      ShotReady   = 1'b0;
      ResultValid = 1'b0;
      NumHits     = 4'd0;
      BigUsed     = 1'b0;
      GameOver    = 1'b0;
      Won         = 1'b0;
      case (state)
         IDLE: ;
         READY: begin
            ShotReady = 1'b1;
            if (ShotValid && coord_ok)
               next_state = SCAN;
         end
         SCAN: begin
            if (cell_idx == last_idx)
               next_state = REPORT;
         end
         REPORT: begin
            ResultValid = 1'b1;
            NumHits     = acc;
            BigUsed     = eff_big;
            if (new_total == 5'd19 || new_shots == '0)
               next_state = DONE;
            else
               next_state = READY;
         end
         DONE: begin
            GameOver = 1'b1;
            Won      = (TotalHits == 5'd19);
         end
         default: next_state = IDLE;
      endcase
      if (NewGame)
         next_state = READY;
   end

   assign Invalid = invalid_q;

   // Per-game datapath: the hit map, the counters, the latched shot, and the
   // scan accumulator.
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_map   <= '0;
         lat_x     <= '0;
         lat_y     <= '0;
         eff_big   <= 1'b0;
         cell_idx  <= '0;
         acc       <= '0;
         invalid_q <= 1'b0;
         TotalHits <= '0;
         ShotsLeft <= '0;
         BigLeft   <= '0;
      end else if (NewGame) begin
         hit_map   <= '0;
         eff_big   <= 1'b0;
         cell_idx  <= '0;
         acc       <= '0;
         invalid_q <= 1'b0;
         TotalHits <= '0;
         ShotsLeft <= SW'(MAX_SHOTS);
         BigLeft   <= BW'(MAX_BIG);
      end else begin
         invalid_q <= 1'b0;
         case (state)
            READY: begin
               if (ShotValid) begin
                  if (!coord_ok) begin
                     invalid_q <= 1'b1;
                  end else begin
                     lat_x    <= X;
                     lat_y    <= Y;
                     eff_big  <= Big && (BigLeft != '0);
                     cell_idx <= '0;
                     acc      <= '0;
                  end
               end
            end
            SCAN: begin
               if (cell_new) begin
                  hit_map[lookup[4:0]] <= 1'b1;
                  acc                  <= acc + 4'd1;
               end
               cell_idx <= cell_idx + 4'd1;
            end
            REPORT: begin
               TotalHits <= new_total;
               ShotsLeft <= new_shots;
               if (eff_big && BigLeft != '0)
                  BigLeft <= BigLeft - BW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_battleship_shot_ctrl.sv
// Directed testbench for battleship_shot_ctrl. Inputs are driven and outputs
// are sampled on the falling clock edge. Expected values are worked out by
// hand from the fixed ship layout.

module tb_battleship_shot_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       NewGame;
   logic       ShotValid;
   logic [3:0] X, Y;
   logic       Big;
   logic       ShotReady, ResultValid, BigUsed, Invalid, GameOver, Won;
   logic [3:0] NumHits;
   logic [4:0] TotalHits;
   logic [4:0] ShotsLeft;
   logic [1:0] BigLeft;

   int compared   = 0;
   int mismatched = 0;

   battleship_shot_ctrl dut (
      .clock(clock), .reset(reset), .NewGame(NewGame), .ShotValid(ShotValid),
      .X(X), .Y(Y), .Big(Big), .ShotReady(ShotReady), .ResultValid(ResultValid),
      .NumHits(NumHits), .BigUsed(BigUsed), .Invalid(Invalid), .TotalHits(TotalHits),
      .ShotsLeft(ShotsLeft), .BigLeft(BigLeft), .GameOver(GameOver), .Won(Won)
   );

   // 10 ns clock.
   always #5 clock = ~clock;

   // Stops a hung run so that it still reports a failure.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Counts one comparison and reports it when the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Pulses NewGame for one cycle, then returns at a falling edge in READY.
   task automatic startGame();
      NewGame = 1'b1;
      @(negedge clock);
      NewGame = 1'b0;
      @(negedge clock);
   endtask

   // Fires a legal shot and checks the result latency, NumHits and BigUsed.
   // It returns at the falling edge after REPORT, where the counters have
   // already been updated.
   task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y, input logic big,
                                input int expHits, input logic expBig, input string tag);
      int lat;
      checkOutput({tag, "_ready"}, ShotReady, 1);
      ShotValid = 1'b1; X = x; Y = y; Big = big;
      @(negedge clock);
      ShotValid = 1'b0; Big = 1'b0;
      lat = 1;
      while (!ResultValid && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, expBig ? 10 : 2);
      checkOutput({tag, "_numhits"}, NumHits, expHits);
      checkOutput({tag, "_bigused"}, BigUsed, expBig);
      @(negedge clock);
   endtask

   // Fires an out-of-range shot. Invalid must pulse on the next cycle, and
   // ResultValid must stay low.
   task automatic invalidShot(input logic [3:0] x, input logic [3:0] y, input string tag);
      int rv;
      ShotValid = 1'b1; X = x; Y = y; Big = 1'b0;
      @(negedge clock);
      ShotValid = 1'b0;
      checkOutput({tag, "_invalid"}, Invalid, 1);
      checkOutput({tag, "_ready"}, ShotReady, 1);
      rv = 0;
      repeat (4) begin
         if (ResultValid) rv++;
         @(negedge clock);
      end
      checkOutput({tag, "_noresult"}, rv, 0);
   endtask

   logic [3:0] ship_x [19] = '{4'd2, 4'd2, 4'd2, 4'd7, 4'd8, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd1, 4'd2, 4'd3, 4'd4, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
   logic [3:0] ship_y [19] = '{4'd8, 4'd9, 4'd10, 4'd6, 4'd6, 4'd3, 4'd3, 4'd3, 4'd3, 4'd3,
                               4'd2, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};

   initial begin
      int rv;
      reset = 1'b1; NewGame = 1'b0; ShotValid = 1'b0; X = '0; Y = '0; Big = 1'b0;
      repeat (3) @(negedge clock);
      checkOutput("rst_ready", ShotReady, 0);
      checkOutput("rst_shots", ShotsLeft, 0);
      checkOutput("rst_gameover", GameOver, 0);
      checkOutput("rst_result", ResultValid, 0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("idle_ready", ShotReady, 0);

      // First game: normal shots and a repeated hit
      startGame();
      checkOutput("ng_ready", ShotReady, 1);
      checkOutput("ng_shots", ShotsLeft, 20);
      checkOutput("ng_big", BigLeft, 2);
      checkOutput("ng_total", TotalHits, 0);
      checkOutput("ng_gameover", GameOver, 0);
      applyStimulus(4'd5, 4'd3, 1'b0, 1, 1'b0, "n53");
      applyStimulus(4'd5, 4'd3, 1'b0, 0, 1'b0, "n53_again");
      checkOutput("n53_shots", ShotsLeft, 18);
      checkOutput("n53_total", TotalHits, 1);
      applyStimulus(4'd5, 4'd4, 1'b0, 0, 1'b0, "n54");

      // Big bombs, then a big request with no bombs left
      startGame();
      applyStimulus(4'd3, 4'd2, 1'b1, 9, 1'b1, "b32");
      checkOutput("b32_bigleft", BigLeft, 1);
      checkOutput("b32_total", TotalHits, 9);
      applyStimulus(4'd3, 4'd9, 1'b1, 3, 1'b1, "b39");
      checkOutput("b39_bigleft", BigLeft, 0);
      applyStimulus(4'd10, 4'd1, 1'b1, 1, 1'b0, "b101_nobig");
      checkOutput("b101_shots", ShotsLeft, 17);
      checkOutput("b101_total", TotalHits, 13);

      // Big bomb at the corner, plus out-of-range shots
      startGame();
      applyStimulus(4'd10, 4'd1, 1'b1, 2, 1'b1, "edge_b101");
      checkOutput("edge_shots", ShotsLeft, 19);
      invalidShot(4'd0, 4'd5, "inv05");
      invalidShot(4'd11, 4'd3, "inv113");
      checkOutput("inv_shots", ShotsLeft, 19);
      checkOutput("inv_bigleft", BigLeft, 1);

      // Hit all 19 ship cells
      startGame();
      for (int i = 0; i < 19; i++)
         applyStimulus(ship_x[i], ship_y[i], 1'b0, 1, 1'b0, $sformatf("win%0d", i));
      checkOutput("win_gameover", GameOver, 1);
      checkOutput("win_won", Won, 1);
      checkOutput("win_total", TotalHits, 19);
      checkOutput("win_ready", ShotReady, 0);
      checkOutput("win_shots", ShotsLeft, 1);
      rv = 0;
      ShotValid = 1'b1; X = 4'd5; Y = 4'd5;
      repeat (4) begin
         @(negedge clock);
         if (ResultValid || Invalid) rv++;
      end
      ShotValid = 1'b0;
      checkOutput("done_ignore", rv, 0);
      checkOutput("done_total", TotalHits, 19);
      checkOutput("done_gameover", GameOver, 1);

      // Run out of shots without winning
      startGame();
      for (int i = 0; i < 20; i++)
         applyStimulus(4'd10, 4'd10, 1'b0, 0, 1'b0, $sformatf("miss%0d", i));
      checkOutput("lose_gameover", GameOver, 1);
      checkOutput("lose_won", Won, 0);
      checkOutput("lose_shots", ShotsLeft, 0);

      // NewGame in the fourth SCAN cycle of a big shot
      startGame();
      applyStimulus(4'd3, 4'd2, 1'b0, 1, 1'b0, "pre_abort");
      checkOutput("pre_abort_total", TotalHits, 1);
      ShotValid = 1'b1; X = 4'd3; Y = 4'd2; Big = 1'b1;
      @(negedge clock);
      ShotValid = 1'b0; Big = 1'b0;
      rv = 0;
      for (int c = 1; c < 4; c++) begin
         if (ResultValid) rv++;
         @(negedge clock);
      end
      NewGame = 1'b1;
      @(negedge clock);
      NewGame = 1'b0;
      checkOutput("abort_ready", ShotReady, 1);
      checkOutput("abort_shots", ShotsLeft, 20);
      checkOutput("abort_big", BigLeft, 2);
      checkOutput("abort_total", TotalHits, 0);
      repeat (10) begin
         if (ResultValid) rv++;
         @(negedge clock);
      end
      checkOutput("abort_noresult", rv, 0);
      applyStimulus(4'd2, 4'd1, 1'b0, 1, 1'b0, "post_abort");

      // Reset in the middle of a scan
      ShotValid = 1'b1; X = 4'd5; Y = 4'd5; Big = 1'b1;
      @(negedge clock);
      ShotValid = 1'b0; Big = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("midrst_ready", ShotReady, 0);
      checkOutput("midrst_result", ResultValid, 0);
      checkOutput("midrst_shots", ShotsLeft, 0);
      checkOutput("midrst_big", BigLeft, 0);
      checkOutput("midrst_total", TotalHits, 0);
      reset = 1'b0;
      @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
